dds_sweep_gen: RTL and testbench
================================

// Module: dds_sweep_gen
// PURPOSE
//   Parametrised DDS with programmable linear frequency sweep, four waveform types, phase offset and
//   amplitude scaling. Drives an external sine ROM through a fixed-latency port. Sits between the
//   config/control logic and the DAC data path; output is delay-matched across all waveform types.
// PARAMETERS
//   PHASE_W  32  phase accumulator and frequency-word width
//   ADDR_W   12  phase address width (ROM depth 2^ADDR_W)
//   DATA_W   8   output sample width
//   ROM_LAT  1   ROM read latency in cycles (1..3)
// PORTS
//   clk_dds     in   1        DDS clock, all logic on rising edge
//   rst         in   1        reset, synchronous, active-high
//   dds_en      in   1        run enable; low = accumulator held at 0
//   cfg_load    in   1        1-cycle strobe: capture all cfg_* inputs into shadow regs
//   cfg_fstart  in   PHASE_W  sweep start / fixed frequency word
//   cfg_fstop   in   PHASE_W  sweep stop frequency word
//   cfg_fstep   in   PHASE_W  frequency increment per dwell period
//   cfg_dwell   in   16       cycles per step = cfg_dwell+1
//   cfg_mode    in   2        00 fixed, 01 single sweep, 10 repeat sweep, 11 up/down sweep
//   cfg_wave    in   2        00 sine(ROM), 01 square, 10 triangle, 11 sawtooth
//   cfg_pword   in   ADDR_W   phase offset added to address (mod 2^ADDR_W)
//   cfg_amp     in   8        amplitude; scale = (cfg_amp+1)/256
//   rom_addr    out  ADDR_W   registered ROM address
//   rom_data    in   DATA_W   ROM data, valid ROM_LAT cycles after rom_addr
//   dds_out     out  DATA_W   scaled unsigned sample
//   dds_valid   out  1        dds_out carries a sample
//   sweep_done  out  1        1-cycle pulse on sweep end (single/repeat modes)
//   busy        out  1        FSM not in IDLE/HOLD
// BEHAVIOUR
//   - Reset: all outputs 0, shadow regs 0, acc 0, f_cur 0, FSM IDLE.
//   - cfg_load: shadow regs updated next edge; f_cur<=cfg_fstart, acc<=0, dwell cnt<=0, FSM restarts.
//     cfg_load wins over every sweep event in the same cycle.
//   - FSM: IDLE -(dds_en)-> FIXED (mode 00, or fstart>=fstop, or fstep==0) | UP (other modes).
//     UP: every dwell+1 cycles f_cur+=fstep, sum computed PHASE_W+1 bits; if sum>=fstop, f_cur<=fstop:
//       mode 01 -> HOLD (f_cur frozen at fstop, sweep_done pulse); mode 10 -> f_cur<=fstart next step,
//       stay UP, sweep_done pulse; mode 11 -> DOWN.
//     DOWN: f_cur-=fstep; if result<=fstart (or borrow) clamp to fstart -> UP. No sweep_done in mode 11.
//     Any state -(dds_en low)-> IDLE; acc<=0, f_cur<=fstart, dwell cnt<=0.
//   - Accumulator: acc<=acc+f_cur each enabled cycle, wraps mod 2^PHASE_W.
//   - Address: addr = acc[PHASE_W-1 -: ADDR_W] + cfg_pword, wraps; registered into rom_addr.
//   - Waves (a = addr, top DATA_W bits = a_hi): square = a[MSB] ? 0 : all-ones; saw = a_hi;
//     triangle = a[MSB] ? ~(a_hi<<1) : (a_hi<<1); sine = rom_data.
//   - Scale: dds_out = (wave*(cfg_amp+1))>>8, truncating; cfg_amp=255 is unity.
//   - Latency: acc -> rom_addr 1, ROM ROM_LAT, scale 1: acc value to dds_out = ROM_LAT+2 cycles;
//     non-sine waves delayed through a matching shift register.
//   - dds_valid = dds_en delayed ROM_LAT+2 cycles; dds_out forced 0 while dds_valid low.
//   - rst mid-sweep: immediate return to reset state; next run needs a new cfg_load.
// CONFIGURATION
//   DDS_PHASE_DITHER_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst, advances
//     every enabled cycle) added to the bits below the address slice before truncation; reduces spurs.
//   Undefined: plain truncation, no LFSR logic. All TESTING values below assume undefined.
// TESTING (PHASE_W=32, ADDR_W=12, DATA_W=8, ROM_LAT=1)
//   1 Fixed: fstart=32'h0100_0000, mode 00, saw, amp 255, pword 0, dds_en rises ->
//     dds_valid high 3 cycles later, dds_out 0,1,2..255,0 wraps every 256 cycles.
//   2 Single sweep: fstart=0x100, fstop=0x400, fstep=0x100, dwell=3 -> f_cur 0x100/0x200/0x300 held
//     4 cycles each, 0x400 at cycle 12, one sweep_done pulse, busy low, f_cur stays 0x400.
//   3 Up/down: same cfg, mode 11 -> f_cur 0x100..0x400..0x100..0x400 repeating, no sweep_done.
//   4 Square, amp=127, pword 12'h800 -> samples 0/127 with phase inverted vs pword 0.
//   5 Repeat, rst high 1 cycle mid-sweep -> next cycle dds_out=0, dds_valid=0, busy=0, f_cur=0.
//   6 cfg_load with fstep=0 during sweep -> FIXED at new fstart, acc restarts from 0.

Source files
------------

// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: swept-frequency DDS with four waveforms, phase offset and amplitude scaling.
// Define DDS_PHASE_DITHER_EN to add LFSR phase dithering below the address slice.
module dds_sweep_gen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic               clk_dds,
  input  logic               rst,
  input  logic               dds_en,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] cfg_fstart,
  input  logic [PHASE_W-1:0] cfg_fstop,
  input  logic [PHASE_W-1:0] cfg_fstep,
  input  logic [15:0]        cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [1:0]         cfg_wave,
  input  logic [ADDR_W-1:0]  cfg_pword,
  input  logic [7:0]         cfg_amp,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  dds_out,
  output logic               dds_valid,
  output logic               sweep_done,
  output logic               busy
);
  localparam int PROD_W = DATA_W + 9;
  typedef enum logic [2:0] {IDLE, FIXED, UP, DOWN, HOLD} state_t;
  state_t state, state_nx, eff, start;
  logic [PHASE_W-1:0] fstart, fstop, fstep, f_cur, f_nx, acc, phase;
  logic [PHASE_W:0]   sum, diff;
  logic [15:0]        dwell, cnt, cnt_nx;
  logic [1:0]         mode, wave;
  logic [ADDR_W-1:0]  pword, addr;
  logic [7:0]         amp;
  logic               tick, done_nx;
  logic [DATA_W-1:0]  a_hi, tri_v, synth, sample;
  logic [DATA_W-1:0]  wpipe [ROM_LAT+1];
  logic [ROM_LAT+1:0] en_d;
  logic [PROD_W-1:0]  prod;
  assign sum  = {1'b0, f_cur} + {1'b0, fstep};
  assign diff = {1'b0, f_cur} - {1'b0, fstep};
  assign tick = cnt == dwell;
  assign start = (mode == 2'b00 || fstart >= fstop || fstep == '0) ? FIXED : UP;
  // the first enabled cycle out of IDLE already behaves as the target state
  assign eff = state == IDLE ? start : state;
  assign busy = !(state == IDLE || state == HOLD);
  always_ff @(posedge clk_dds) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = eff;
    f_nx = f_cur;
    cnt_nx = '0;
    done_nx = 1'b0;
    if (cfg_load) begin
      state_nx = IDLE;
      f_nx = cfg_fstart;
    end else if (!dds_en) begin
      state_nx = IDLE;
      f_nx = fstart;
    end else if (eff == UP || eff == DOWN) begin
      cnt_nx = tick ? '0 : cnt + 16'd1;
      if (tick) begin
        if (eff == DOWN) begin
          if (diff[PHASE_W] || diff[PHASE_W-1:0] <= fstart) begin
            f_nx = fstart;
            state_nx = UP;
          end else f_nx = diff[PHASE_W-1:0];
        end else if (mode == 2'b10 && f_cur == fstop) f_nx = fstart;
        else if (sum >= {1'b0, fstop}) begin
          f_nx = fstop;
          state_nx = mode == 2'b11 ? DOWN : mode == 2'b01 ? HOLD : UP;
          done_nx = mode != 2'b11;
        end else f_nx = sum[PHASE_W-1:0];
      end
    end
  end
  always_ff @(posedge clk_dds) begin
    if (rst) begin
      {fstart, fstop, fstep, dwell, mode, wave, pword, amp} <= '0;
      f_cur <= '0;
      acc <= '0;
      cnt <= '0;
      sweep_done <= 1'b0;
    end else begin
      f_cur <= f_nx;
      cnt <= cnt_nx;
      sweep_done <= done_nx;
      acc <= (cfg_load || !dds_en) ? '0 : acc + f_cur;
      if (cfg_load)
        {fstart, fstop, fstep, dwell, mode, wave, pword, amp} <=
          {cfg_fstart, cfg_fstop, cfg_fstep, cfg_dwell, cfg_mode, cfg_wave, cfg_pword, cfg_amp};
    end
  end
`ifdef DDS_PHASE_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_dds) begin
    if (rst) lfsr <= 16'hACE1;
    else if (dds_en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign phase = acc + (PHASE_W'(lfsr) << (PHASE_W - ADDR_W - 16));
`else
  assign phase = acc;
`endif
  assign addr  = phase[PHASE_W-1 -: ADDR_W] + pword;
  assign a_hi  = addr[ADDR_W-1 -: DATA_W];
  assign tri_v = {a_hi[DATA_W-2:0], 1'b0};
  assign synth = wave == 2'b01 ? (addr[ADDR_W-1] ? '0 : '1) :
                 wave == 2'b10 ? (addr[ADDR_W-1] ? ~tri_v : tri_v) : a_hi;
  // synthetic waves ride a shift register so every type matches the ROM latency
  assign sample = wave == 2'b00 ? rom_data : wpipe[ROM_LAT];
  assign prod = PROD_W'(sample) * PROD_W'({1'b0, amp} + 9'd1);
  assign dds_valid = en_d[ROM_LAT+1];
  always_ff @(posedge clk_dds) begin
    if (rst) begin
      rom_addr <= '0;
      en_d <= '0;
      dds_out <= '0;
      for (int i = 0; i <= ROM_LAT; i++) wpipe[i] <= '0;
    end else begin
      rom_addr <= addr;
      en_d <= {en_d[ROM_LAT:0], dds_en};
      wpipe[0] <= synth;
      for (int i = 1; i <= ROM_LAT; i++) wpipe[i] <= wpipe[i-1];
      dds_out <= en_d[ROM_LAT] ? DATA_W'(prod >> 8) : '0;
    end
  end
endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb_dds_sweep_gen: randomized scoreboard bench for dds_sweep_gen against a sweep-list reference model.
module tb_dds_sweep_gen;
  localparam int RL = 1;
  logic clk_dds = 1'b0;
  always #5 clk_dds = ~clk_dds;
  logic        rst, dds_en, cfg_load;
  logic [31:0] cfg_fstart, cfg_fstop, cfg_fstep;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode, cfg_wave;
  logic [11:0] cfg_pword, rom_addr;
  logic [7:0]  cfg_amp, rom_data, dds_out;
  logic        dds_valid, sweep_done, busy;
  dds_sweep_gen #(.PHASE_W(32), .ADDR_W(12), .DATA_W(8), .ROM_LAT(RL)) dut (
    .clk_dds(clk_dds), .rst(rst), .dds_en(dds_en), .cfg_load(cfg_load),
    .cfg_fstart(cfg_fstart), .cfg_fstop(cfg_fstop), .cfg_fstep(cfg_fstep), .cfg_dwell(cfg_dwell),
    .cfg_mode(cfg_mode), .cfg_wave(cfg_wave), .cfg_pword(cfg_pword), .cfg_amp(cfg_amp),
    .rom_addr(rom_addr), .rom_data(rom_data), .dds_out(dds_out), .dds_valid(dds_valid),
    .sweep_done(sweep_done), .busy(busy)
  );
  function automatic logic [7:0] rom_f(logic [11:0] a);
    return 8'((a * 7) ^ (a >> 4));
  endfunction
  always @(posedge clk_dds) rom_data <= rom_f(rom_addr);
  int n_chk = 0, n_fail = 0;
  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: a run is described by its list of step frequencies
  longint      m_fs, m_fe, m_st, L[$];
  int          m_dw, m_mode, m_wave, k;
  logic [11:0] m_pw;
  logic [7:0]  m_amp;
  logic [31:0] m_acc;
  bit          m_fixed;
  logic [7:0]  q[$];
  function automatic void build();
    m_fixed = m_mode == 0 || m_fs >= m_fe || m_st == 0;
    L.delete();
    if (!m_fixed) begin
      for (longint f = m_fs; f < m_fe; f += m_st) L.push_back(f);
      L.push_back(m_fe);
      if (m_mode == 3) for (longint f = m_fe - m_st; f > m_fs; f -= m_st) L.push_back(f);
    end
  endfunction
  function automatic longint f_at(int kk);
    int i = kk / (m_dw + 1);
    if (m_fixed) return m_fs;
    if (m_mode == 1) return L[i < L.size() ? i : L.size() - 1];
    return L[i % L.size()];
  endfunction
  function automatic bit done_at(int kk);
    int i = kk / (m_dw + 1);
    if (m_fixed || m_mode == 3 || kk == 0 || kk % (m_dw + 1) != 0) return 1'b0;
    return m_mode == 1 ? i == L.size() - 1 : i % L.size() == L.size() - 1;
  endfunction
  function automatic bit busy_at(int kk);
    if (kk == 0) return 1'b0;
    if (!m_fixed && m_mode == 1 && kk / (m_dw + 1) >= L.size() - 1) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [7:0] exp_out(logic [31:0] acc);
    logic [11:0] a;
    logic [7:0]  hi, t, w;
    a = acc[31:20] + m_pw;
    hi = a[11:4];
    t = hi << 1;
    case (m_wave)
      0: w = rom_f(a);
      1: w = a[11] ? 8'h00 : 8'hFF;
      2: w = a[11] ? ~t : t;
      default: w = hi;
    endcase
    return 8'((int'(w) * (int'(m_amp) + 1)) / 256);
  endfunction
  function automatic void model_reset();
    m_fs = 0; m_fe = 0; m_st = 0; m_dw = 0; m_mode = 0; m_wave = 0; m_pw = '0; m_amp = '0;
    m_acc = '0; k = 0;
    build();
  endfunction
  always @(negedge clk_dds) begin
    if (dds_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("dds_out", dds_out, q.pop_front());
    end else chk("dds_out_idle", dds_out, 0);
  end
  task automatic cyc();
    chk("busy", busy, busy_at(k));
    chk("sweep_done", sweep_done, done_at(k));
    chk("f_cur", dut.f_cur, f_at(k));
    if (rst) model_reset();
    else begin
      if (dds_en) q.push_back(exp_out(m_acc));
      if (cfg_load) begin
        m_fs = cfg_fstart; m_fe = cfg_fstop; m_st = cfg_fstep; m_dw = cfg_dwell;
        m_mode = cfg_mode; m_wave = cfg_wave; m_pw = cfg_pword; m_amp = cfg_amp;
        build();
        m_acc = '0; k = 0;
      end else if (!dds_en) begin
        m_acc = '0; k = 0;
      end else begin
        m_acc += 32'(f_at(k));
        k++;
      end
    end
    @(posedge clk_dds);
    #1;
    if (rst) q.delete();
    cfg_load = 1'b0;
  endtask
  task automatic load(logic [31:0] fs, logic [31:0] fe, logic [31:0] st, logic [15:0] dw,
                      logic [1:0] md, logic [1:0] wv, logic [11:0] pw, logic [7:0] amp);
    cfg_fstart = fs; cfg_fstop = fe; cfg_fstep = st; cfg_dwell = dw;
    cfg_mode = md; cfg_wave = wv; cfg_pword = pw; cfg_amp = amp;
    cfg_load = 1'b1;
    cyc();
  endtask
  task automatic run(int n);
    dds_en = 1'b1;
    repeat (n) cyc();
    dds_en = 1'b0;
    repeat (RL + 4) cyc();
    chk("drained", q.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] fs, span, fe, st;
    rst = 1'b1; dds_en = 1'b0; cfg_load = 1'b0;
    cfg_fstart = '0; cfg_fstop = '0; cfg_fstep = '0; cfg_dwell = '0;
    cfg_mode = '0; cfg_wave = '0; cfg_pword = '0; cfg_amp = '0;
    model_reset();
    repeat (2) @(posedge clk_dds);
    #1;
    chk("rst_dds_out", dds_out, 0);
    chk("rst_valid", dds_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    // fixed sawtooth: valid three cycles after enable, output counts 0..255
    load(32'h0100_0000, 32'h0, 32'h0, 16'd0, 2'b00, 2'b11, 12'h000, 8'd255);
    dds_en = 1'b1;
    cyc(); chk("lat_valid1", dds_valid, 0);
    cyc(); chk("lat_valid2", dds_valid, 0);
    cyc(); chk("lat_valid3", dds_valid, 1);
    chk("first_sample", dds_out, 0);
    run(600);
    load(32'h100, 32'h400, 32'h100, 16'd3, 2'b01, 2'b11, 12'h000, 8'd255);
    run(40);
    load(32'h100, 32'h400, 32'h100, 16'd3, 2'b11, 2'b11, 12'h000, 8'd255);
    run(80);
    load(32'h0040_0000, 32'h0, 32'h0, 16'd0, 2'b00, 2'b01, 12'h800, 8'd127);
    run(120);
    load(32'h0040_0000, 32'h0, 32'h0, 16'd0, 2'b00, 2'b01, 12'h000, 8'd127);
    run(120);
    // reset in the middle of a repeating sweep
    load(32'h0020_0000, 32'h0080_0000, 32'h0010_0000, 16'd2, 2'b10, 2'b10, 12'h123, 8'd200);
    dds_en = 1'b1;
    repeat (10) cyc();
    rst = 1'b1; dds_en = 1'b0;
    cyc();
    rst = 1'b0;
    chk("midrst_out", dds_out, 0);
    chk("midrst_valid", dds_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fcur", dut.f_cur, 0);
    repeat (4) cyc();
    // reload to fixed mid-sweep: accumulator restarts from zero at the new frequency
    load(32'h0020_0000, 32'h0080_0000, 32'h0010_0000, 16'd1, 2'b10, 2'b00, 12'h040, 8'd180);
    dds_en = 1'b1;
    repeat (13) cyc();
    load(32'h0300_0000, 32'h0080_0000, 32'h0, 16'd1, 2'b10, 2'b00, 12'h040, 8'd180);
    run(60);
    repeat (14) begin
      fs = $urandom_range(1 << 20, 1 << 26);
      span = $urandom_range(0, 1 << 26);
      fe = ($urandom_range(0, 4) == 0) ? fs - 32'd1000 : fs + span;
      st = ($urandom_range(0, 4) == 0) ? 32'd0 : span / $urandom_range(1, 10) + 32'd1;
      load(fs, fe, st, 16'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 12'($urandom), 8'($urandom));
      run($urandom_range(50, 300));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
